ascii_operand_parser: RTL and testbench
=======================================

Name: ascii_operand_parser

Overview:
Upstream input stage for the 5-bit adder/subtractor. It consumes an ASCII character stream of the form two decimal digits, newline, two decimal digits, newline, then '+' or '-'. It converts this into binary operands X and Y and a subtract select. The parsed triple goes to the adder/subtractor through a valid/ready handshake. Malformed input is flagged, and the parser then resynchronises on the next newline.

Parameters:
WIDTH, 5, operand width in bits (matches the adder/subtractor datapath)
MAX_VAL, 15, largest legal decimal operand; must be <= 2**WIDTH-1

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
in_char  input  8  ASCII character
in_valid  input  1  in_char is valid this cycle
in_ready  output  1  parser accepts in_char this cycle
x_out  output  WIDTH  parsed X operand
y_out  output  WIDTH  parsed Y operand
sub_out  output  1  0 = add ('+'), 1 = subtract ('-'); drives the adder's add/sub select and C0
op_valid  output  1  x_out/y_out/sub_out hold a complete operation
op_ready  input  1  downstream consumes the operation
err  output  1  one-cycle pulse on a parse error
err_code  output  2  01 bad digit, 10 out of range, 11 bad separator/operator; holds last value

Behaviour:
- Reset values: state X_HI; x_out=0, y_out=0, sub_out=0, op_valid=0, err=0, err_code=00. in_ready=1 after reset.
- Reset mid-operation discards all partial digits. Synchronous reset wins over any simultaneous accept.
- A character is accepted when in_valid && in_ready, and at most one character is accepted per cycle.
- in_ready=1 in every state except OUT.
- States and transitions on an accepted character:
  - X_HI: 0x0A/0x0D are consumed and ignored. A digit ('0'..'9', 0x30-0x39) stores hi=char-0x30 and moves to X_LO. Anything else is error 01.
  - X_LO: a digit gives value=hi*10+(char-0x30), computed in 7 bits. If value <= MAX_VAL, x_out is loaded and the state moves to X_NL. If value > MAX_VAL, error 10. A non-digit is error 01.
  - X_NL: 0x0D is ignored. 0x0A moves to Y_HI. Anything else is error 11.
  - Y_HI, Y_LO, Y_NL: identical to the X states, loading y_out. Y_NL exits to OPR.
  - OPR: 0x0D/0x0A are ignored. '+' (0x2B) sets sub_out=0; '-' (0x2D) sets sub_out=1; either moves to OUT. Anything else is error 11.
  - OUT: op_valid=1. x_out, y_out and sub_out are stable until op_valid && op_ready. The cycle after the handshake, the state is X_HI with op_valid=0.
- Latency: op_valid rises in the cycle after the operator character is accepted. If op_ready is already high, the handshake completes in that same cycle.
- Error handling:
  - err pulses high for one cycle, the cycle after the offending character is accepted. err_code is updated in the same cycle.
  - The state becomes DRAIN. DRAIN keeps in_ready=1 and discards characters until a 0x0A is accepted, then returns to X_HI.
  - x_out/y_out may hold partial values after an error; op_valid is never asserted for an errored operation.
- No wrap-around: the range check runs on the full 7-bit value before truncation to WIDTH.

Decomposition:
- Shared package addsub_pkg:
  - ASCII constants: ZERO=0x30, NINE=0x39, LF=0x0A, CR=0x0D, PLUS=0x2B, MINUS=0x2D
  - state enum: X_HI, X_LO, X_NL, Y_HI, Y_LO, Y_NL, OPR, OUT, DRAIN
  - err_code constants: ERR_DIGIT, ERR_RANGE, ERR_SEP
- One combinational sub-module, dec2_to_bin. Inputs: hi digit and lo char. Outputs: is_digit, 7-bit value, in_range against MAX_VAL. It is instantiated once and shared by the X and Y paths.

Test Plan:
- Stream "07\n12\n+" with op_ready=1 -> op_valid for 1 cycle, one cycle after '+'; x_out=00111, y_out=01100, sub_out=0; err never asserted.
- Stream "15\n03\n-" with op_ready low for 3 cycles after op_valid -> x_out=01111, y_out=00011, sub_out=1 held stable; in_ready=0 throughout OUT; accept resumes the cycle after the handshake.
- Stream "19\n01\n02\n+" -> err pulse with err_code=10 after '9'. The following "\n" is drained, then x=1, y=2, sub=0 is delivered.
- Stream "0a\n" then "05\n05\n*\n" -> err_code=01 after 'a'. After the drain, a second error with err_code=11 after '*'; op_valid never asserted.
- Stream "\r\n04\r\n09\r\n+" -> CR/LF tolerated; x=4, y=9, sub=0.
- Assert rst for 1 cycle after "03\n1", then stream "02\n06\n-" -> outputs are at reset values immediately after reset; result is x=2, y=6, sub=1.

Source files
------------

// File: rtl/addsub_pkg.sv
// Shared definitions for the ASCII operand parser that feeds the 5-bit
// adder/subtractor: datapath widths, ASCII constants, parser states and
// error codes.
package addsub_pkg;

  localparam int unsigned DEF_WIDTH   = 5;   // operand width of the adder/subtractor
  localparam int unsigned DEF_MAX_VAL = 15;  // largest legal decimal operand
  localparam int unsigned VAL_W       = 7;   // two decimal digits (0..99) fit in 7 bits
  localparam int unsigned CHAR_W      = 8;
  localparam int unsigned DIGIT_W     = 4;
  localparam int unsigned ERR_W       = 2;

  localparam logic [CHAR_W-1:0] ZERO  = 8'h30;
  localparam logic [CHAR_W-1:0] NINE  = 8'h39;
  localparam logic [CHAR_W-1:0] LF    = 8'h0A;
  localparam logic [CHAR_W-1:0] CR    = 8'h0D;
  localparam logic [CHAR_W-1:0] PLUS  = 8'h2B;
  localparam logic [CHAR_W-1:0] MINUS = 8'h2D;

  localparam logic [ERR_W-1:0] ERR_NONE  = 2'b00;
  localparam logic [ERR_W-1:0] ERR_DIGIT = 2'b01;
  localparam logic [ERR_W-1:0] ERR_RANGE = 2'b10;
  localparam logic [ERR_W-1:0] ERR_SEP   = 2'b11;

  typedef enum logic [3:0] {
    X_HI, X_LO, X_NL,
    Y_HI, Y_LO, Y_NL,
    OPR, OUT, DRAIN
  } state_t;

endpackage

// File: rtl/ascii_operand_parser_if.sv
// Bus between the character source / operation consumer and the parser.
//   in_char/in_valid/in_ready : ASCII character stream into the parser
//   x_out/y_out/sub_out       : parsed operation, qualified by op_valid
//   op_valid/op_ready         : operation handshake towards the adder/subtractor
//   err/err_code              : parse-error pulse and sticky error code
// modport slave  : the parser (accepts characters, presents operations)
// modport master : the environment (sends characters, consumes operations)
interface ascii_operand_parser_if
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) ();

  logic [CHAR_W-1:0] in_char;
  logic              in_valid;
  logic              in_ready;
  logic [WIDTH-1:0]  x_out;
  logic [WIDTH-1:0]  y_out;
  logic              sub_out;
  logic              op_valid;
  logic              op_ready;
  logic              err;
  logic [ERR_W-1:0]  err_code;

  modport slave (
    input  in_char, in_valid, op_ready,
    output in_ready, x_out, y_out, sub_out, op_valid, err, err_code
  );

  modport master (
    output in_char, in_valid, op_ready,
    input  in_ready, x_out, y_out, sub_out, op_valid, err, err_code
  );

endinterface

// File: rtl/dec2_to_bin.sv
// Combinational two-digit decimal to binary converter.
//   hi       : previously stored tens digit (0..9)
//   lo_char  : ASCII character offered as the units digit
//   is_digit : lo_char is '0'..'9'
//   value    : hi*10 + (lo_char-'0') in 7 bits (meaningful when is_digit)
//   in_range : value <= MAX_VAL, checked before any truncation
module dec2_to_bin
  import addsub_pkg::*;
#(
  parameter int unsigned MAX_VAL = DEF_MAX_VAL
) (
  input  logic [DIGIT_W-1:0] hi,
  input  logic [CHAR_W-1:0]  lo_char,
  output logic               is_digit,
  output logic [VAL_W-1:0]   value,
  output logic               in_range
);

  always_comb begin
    is_digit = (lo_char >= ZERO) && (lo_char <= NINE);
    value    = (VAL_W'(hi) * VAL_W'(10)) + VAL_W'(lo_char - ZERO);
    in_range = (value <= VAL_W'(MAX_VAL));
  end

endmodule

// File: rtl/ascii_operand_parser.sv
// ASCII front end for the adder/subtractor: parses "DD\nDD\n+" / "DD\nDD\n-"
// into X, Y and a subtract select, hands them over with valid/ready, flags
// malformed input and resynchronises on the next LF.
//   clk  : rising-edge clock
//   rst  : synchronous, active-high reset
//   bus  : character stream in, operation + error status out (slave modport)
module ascii_operand_parser
  import addsub_pkg::*;
#(
  parameter int unsigned WIDTH   = DEF_WIDTH,
  parameter int unsigned MAX_VAL = DEF_MAX_VAL
) (
  input  logic                   clk,
  input  logic                   rst,
  ascii_operand_parser_if.slave  bus
);

  state_t             state_q, state_d;
  logic [DIGIT_W-1:0] hi_q, hi_d;
  logic [WIDTH-1:0]   x_q, x_d, y_q, y_d;
  logic               sub_q, sub_d;
  logic               op_valid_q, op_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               err_q, err_d;
  logic [ERR_W-1:0]   code_q, code_d;

  logic               accept;
  logic               fault;
  logic [ERR_W-1:0]   fault_code;
  logic               is_digit;
  logic               in_range;
  logic [VAL_W-1:0]   value;

  // Single converter shared by the X and Y digit states.
  dec2_to_bin #(.MAX_VAL(MAX_VAL)) u_dec (
    .hi       (hi_q),
    .lo_char  (bus.in_char),
    .is_digit (is_digit),
    .value    (value),
    .in_range (in_range)
  );

  assign accept = bus.in_valid && in_ready_q;

  // State and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= X_HI;
      hi_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sub_q      <= 1'b0;
      op_valid_q <= 1'b0;
      in_ready_q <= 1'b1;
      err_q      <= 1'b0;
      code_q     <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      hi_q       <= hi_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sub_q      <= sub_d;
      op_valid_q <= op_valid_d;
      in_ready_q <= in_ready_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d    = state_q;
    hi_d       = hi_q;
    x_d        = x_q;
    y_d        = y_q;
    sub_d      = sub_q;
    code_d     = code_q;
    err_d      = 1'b0;
    fault      = 1'b0;
    fault_code = ERR_DIGIT;

    unique case (state_q)
      X_HI, Y_HI: begin
        if (accept && (bus.in_char != LF) && (bus.in_char != CR)) begin
          if (is_digit) begin
            hi_d    = DIGIT_W'(bus.in_char - ZERO);
            state_d = (state_q == X_HI) ? X_LO : Y_LO;
          end else begin
            fault      = 1'b1;
            fault_code = ERR_DIGIT;
          end
        end
      end
      X_LO, Y_LO: begin
        if (accept) begin
          if (!is_digit) begin
            fault      = 1'b1;
            fault_code = ERR_DIGIT;
          end else if (!in_range) begin
            fault      = 1'b1;
            fault_code = ERR_RANGE;
          end else if (state_q == X_LO) begin
            x_d     = WIDTH'(value);
            state_d = X_NL;
          end else begin
            y_d     = WIDTH'(value);
            state_d = Y_NL;
          end
        end
      end
      X_NL, Y_NL: begin
        if (accept && (bus.in_char != CR)) begin
          if (bus.in_char == LF) begin
            state_d = (state_q == X_NL) ? Y_HI : OPR;
          end else begin
            fault      = 1'b1;
            fault_code = ERR_SEP;
          end
        end
      end
      OPR: begin
        if (accept && (bus.in_char != LF) && (bus.in_char != CR)) begin
          if ((bus.in_char == PLUS) || (bus.in_char == MINUS)) begin
            sub_d   = (bus.in_char == MINUS);
            state_d = OUT;
          end else begin
            fault      = 1'b1;
            fault_code = ERR_SEP;
          end
        end
      end
      OUT: begin
        if (op_valid_q && bus.op_ready) begin
          state_d = X_HI;
        end
      end
      DRAIN: begin
        if (accept && (bus.in_char == LF)) begin
          state_d = X_HI;
        end
      end
      default: state_d = X_HI;
    endcase

    // Any parse error discards the operation and waits for the next LF.
    if (fault) begin
      state_d = DRAIN;
      err_d   = 1'b1;
      code_d  = fault_code;
    end

    // Handshake flags are registered decodes of the next state.
    op_valid_d = (state_d == OUT);
    in_ready_d = (state_d != OUT);
  end

  assign bus.in_ready = in_ready_q;
  assign bus.x_out    = x_q;
  assign bus.y_out    = y_q;
  assign bus.sub_out  = sub_q;
  assign bus.op_valid = op_valid_q;
  assign bus.err      = err_q;
  assign bus.err_code = code_q;

endmodule

// File: tb/tb_ascii_operand_parser.sv
// Self-checking bench for ascii_operand_parser: a field-level reference model
// tracks what every output must be; a monitor compares on each falling edge,
// and directed streams pin selected values with hand-computed literals.
module tb_ascii_operand_parser;

  localparam int W       = 5;
  localparam int MAXV    = 15;

  logic clk = 1'b0;
  logic rst;

  ascii_operand_parser_if #(.WIDTH(W)) pif ();

  ascii_operand_parser #(.WIDTH(W), .MAX_VAL(MAXV)) dut (
    .clk (clk),
    .rst (rst),
    .bus (pif)
  );

  always #5 clk = ~clk;

  // Reference model: which field is being read, how many digits of it so far.
  typedef struct {
    int x;
    int y;
    int sub;
    int pend;
    int err;
    int code;
    int fld;
    int ndig;
    int hi;
    int drain;
  } m_t;

  m_t m;

  function automatic m_t model_reset();
    m_t r;
    r.x = 0; r.y = 0; r.sub = 0; r.pend = 0; r.err = 0; r.code = 0;
    r.fld = 0; r.ndig = 0; r.hi = 0; r.drain = 0;
    return r;
  endfunction

  function automatic m_t model_step(m_t cur, logic v, logic [7:0] c, logic rdy);
    m_t n;
    int e;
    int d;
    bit dig;
    n     = cur;
    n.err = 0;
    e     = 0;
    dig   = (c >= 8'h30) && (c <= 8'h39);
    d     = int'(c) - 48;
    if (cur.pend != 0) begin
      if (rdy) n.pend = 0;
      return n;
    end
    if (!v) return n;
    if (cur.drain != 0) begin
      if (c == 8'h0A) n.drain = 0;
      return n;
    end
    if (cur.fld < 2) begin
      if (cur.ndig == 0) begin
        if (c == 8'h0A || c == 8'h0D) begin end
        else if (dig) begin n.hi = d; n.ndig = 1; end
        else e = 1;
      end else if (cur.ndig == 1) begin
        if (!dig) e = 1;
        else if (cur.hi * 10 + d > MAXV) e = 2;
        else begin
          if (cur.fld == 0) n.x = cur.hi * 10 + d;
          else n.y = cur.hi * 10 + d;
          n.ndig = 2;
        end
      end else begin
        if (c == 8'h0D) begin end
        else if (c == 8'h0A) begin n.fld = cur.fld + 1; n.ndig = 0; end
        else e = 3;
      end
    end else begin
      if (c == 8'h0A || c == 8'h0D) begin end
      else if (c == 8'h2B) begin n.sub = 0; n.pend = 1; n.fld = 0; end
      else if (c == 8'h2D) begin n.sub = 1; n.pend = 1; n.fld = 0; end
      else e = 3;
    end
    if (e != 0) begin
      n.err = 1; n.code = e; n.drain = 1; n.fld = 0; n.ndig = 0;
    end
    return n;
  endfunction

  always @(posedge clk) begin
    if (rst) m <= model_reset();
    else     m <= model_step(m, pif.in_valid, pif.in_char, pif.op_ready);
  end

  int n_cmp = 0;
  int n_bad = 0;
  bit mon_on = 1'b0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("in_ready", 32'(pif.in_ready), (m.pend != 0) ? 32'd0 : 32'd1);
    chk("op_valid", 32'(pif.op_valid), 32'(m.pend));
    chk("err",      32'(pif.err),      32'(m.err));
    chk("err_code", 32'(pif.err_code), 32'(m.code));
    chk("x_out",    32'(pif.x_out),    32'(m.x));
    chk("y_out",    32'(pif.y_out),    32'(m.y));
    chk("sub_out",  32'(pif.sub_out),  32'(m.sub));
  endtask

  task automatic send(input logic [7:0] c);
    pif.in_char  = c;
    pif.in_valid = 1'b1;
    for (int n = 0; n < 50 && !pif.in_ready; n++) @(negedge clk);
    if (!pif.in_ready) chk("in_ready_timeout", 32'(pif.in_ready), 32'd1);
    @(negedge clk);
    pif.in_valid = 1'b0;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send(s[i]);
  endtask

  // Called right after the operator is accepted with op_ready high.
  task automatic expect_op(input int ex, input int ey, input int es);
    chk("lit_op_valid", 32'(pif.op_valid), 32'd1);
    chk("lit_x",        32'(pif.x_out),    32'(ex));
    chk("lit_y",        32'(pif.y_out),    32'(ey));
    chk("lit_sub",      32'(pif.sub_out),  32'(es));
    @(negedge clk);
    chk("lit_op_done",  32'(pif.op_valid), 32'd0);
    chk("lit_ready",    32'(pif.in_ready), 32'd1);
  endtask

  initial begin
    rst          = 1'b1;
    pif.in_valid = 1'b0;
    pif.in_char  = 8'h00;
    pif.op_ready = 1'b1;

    fork
      forever begin
        @(negedge clk);
        if (mon_on) check_model();
      end
      begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
      end
    join_none

    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_x",        32'(pif.x_out),    32'd0);
    chk("rst_op_valid", 32'(pif.op_valid), 32'd0);
    chk("rst_ready",    32'(pif.in_ready), 32'd1);
    chk("rst_code",     32'(pif.err_code), 32'd0);
    mon_on = 1'b1;

    // Basic add with downstream always ready.
    send_str("07\n12\n+");
    expect_op(7, 12, 0);

    // Subtract with back-pressure: outputs held, input stalled.
    pif.op_ready = 1'b0;
    send_str("15\n03\n-");
    for (int i = 0; i < 3; i++) begin
      chk("bp_op_valid", 32'(pif.op_valid), 32'd1);
      chk("bp_ready",    32'(pif.in_ready), 32'd0);
      chk("bp_x",        32'(pif.x_out),    32'd15);
      chk("bp_y",        32'(pif.y_out),    32'd3);
      chk("bp_sub",      32'(pif.sub_out),  32'd1);
      if (i < 2) @(negedge clk);
    end
    pif.op_ready = 1'b1;
    @(negedge clk);
    chk("bp_done",  32'(pif.op_valid), 32'd0);
    chk("bp_resume", 32'(pif.in_ready), 32'd1);

    // Out of range (19 > 15), then recovery.
    send_str("19");
    chk("range_err",  32'(pif.err),      32'd1);
    chk("range_code", 32'(pif.err_code), 32'd2);
    send_str("\n01\n02\n+");
    expect_op(1, 2, 0);

    // Bad digit, then bad operator after resync.
    send_str("0a");
    chk("digit_err",  32'(pif.err),      32'd1);
    chk("digit_code", 32'(pif.err_code), 32'd1);
    send_str("\n05\n05\n*");
    chk("sep_err",  32'(pif.err),      32'd1);
    chk("sep_code", 32'(pif.err_code), 32'd3);
    send_str("\n");
    chk("sep_no_op", 32'(pif.op_valid), 32'd0);

    // CR/LF tolerance.
    send_str("\r\n04\r\n09\r\n+");
    expect_op(4, 9, 0);

    // Reset mid-operation discards partial state.
    send_str("03\n1");
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_x",     32'(pif.x_out),    32'd0);
    chk("mid_rst_y",     32'(pif.y_out),    32'd0);
    chk("mid_rst_code",  32'(pif.err_code), 32'd0);
    chk("mid_rst_ready", 32'(pif.in_ready), 32'd1);
    send_str("02\n06\n-");
    expect_op(2, 6, 1);

    repeat (3) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
